// File: rtl/dma_byte_fifo_if.sv
// DMA <-> line-driver byte FIFO bundle.
// master: DMA/driver side, slave: FIFO side.
interface dma_byte_fifo_if;
  logic        flush;
  logic        write_1;
  logic [7:0]  data_in_FIFO_1;
  logic        read_1;
  logic [7:0]  data_out_FIFO_1;
  logic        valid_out;
  logic        full_FIFO;
  logic        empty_FIFO;
  logic        almost_full;
  logic        almost_empty;
  logic        error_FIFO;
  logic [11:0] block_size;
  logic        block_done;

  modport master (
    output flush,
    output write_1,
    output data_in_FIFO_1,
    output read_1,
    output block_size,
    input  data_out_FIFO_1,
    input  valid_out,
    input  full_FIFO,
    input  empty_FIFO,
    input  almost_full,
    input  almost_empty,
    input  error_FIFO,
    input  block_done
  );

  modport slave (
    input  flush,
    input  write_1,
    input  data_in_FIFO_1,
    input  read_1,
    input  block_size,
    output data_out_FIFO_1,
    output valid_out,
    output full_FIFO,
    output empty_FIFO,
    output almost_full,
    output almost_empty,
    output error_FIFO,
    output block_done
  );
endinterface

// File: rtl/dma_byte_fifo.sv
// Byte FIFO between DMA and card data lines, with block counter.
// Ports: clk_in_1, reset_1 (sync, low), bus (slave); DMA_FIFO_STATUS_EN adds level/stickies.
module dma_byte_fifo #(
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2
) (
  input  logic                    clk_in_1,
  input  logic                    reset_1,
  dma_byte_fifo_if.slave          bus
`ifdef DMA_FIFO_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    ovf_sticky,
  output logic                    udf_sticky
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_V  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_V = (AW+1)'(AEMPTY_TH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic [AW:0]   occ_nxt;

  logic          push_ok;
  logic          pop_ok;
  logic          rej;
  logic          clr;

  logic [11:0]   blk_cnt;
  logic [12:0]   blk_len;
  logic [12:0]   len_eff;
  logic [12:0]   cnt_inc;
  logic          blk_end;

  assign clr = !reset_1 || bus.flush;

  // A push into a full FIFO is fine when a pop frees a slot
  // in the same cycle; pops look only at the current contents.
  always_comb begin
    push_ok = bus.write_1 && (!bus.full_FIFO || bus.read_1);
    pop_ok  = bus.read_1 && !bus.empty_FIFO;
    rej     = (bus.write_1 && !push_ok)
            || (bus.read_1 && !pop_ok);
  end

  always_comb begin
    occ_nxt = occ;
    unique case (1'b1)
      push_ok && !pop_ok: occ_nxt = occ + 1'b1;
      !push_ok && pop_ok: occ_nxt = occ - 1'b1;
      default:            occ_nxt = occ;
    endcase
  end

  // Length is taken from block_size on the first pop of a
  // block; zero encodes the full 4096-byte block.
  always_comb begin
    len_eff = blk_len;
    if (blk_cnt == 12'd0) begin
      if (bus.block_size == 12'd0) len_eff = 13'd4096;
      else len_eff = {1'b0, bus.block_size};
    end
    cnt_inc = {1'b0, blk_cnt} + 13'd1;
    blk_end = (cnt_inc == len_eff);
  end

  always_ff @(posedge clk_in_1) begin
    if (!clr && push_ok)
      mem[wr_ptr] <= bus.data_in_FIFO_1;
  end

  always_ff @(posedge clk_in_1) begin
    if (clr) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      occ              <= '0;
      bus.valid_out    <= 1'b0;
      bus.full_FIFO    <= 1'b0;
      bus.empty_FIFO   <= 1'b1;
      bus.almost_full  <= 1'b0;
      bus.almost_empty <= 1'b1;
      bus.error_FIFO   <= 1'b0;
      bus.block_done   <= 1'b0;
      blk_cnt          <= '0;
      blk_len          <= '0;
      // Flush keeps the last byte visible; only reset zeroes it.
      if (!reset_1)
        bus.data_out_FIFO_1 <= 8'h00;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr              <= rd_ptr + 1'b1;
        bus.data_out_FIFO_1 <= mem[rd_ptr];
        if (blk_cnt == 12'd0)
          blk_len <= len_eff;
        if (blk_end)
          blk_cnt <= '0;
        else
          blk_cnt <= cnt_inc[11:0];
      end
      occ              <= occ_nxt;
      bus.valid_out    <= pop_ok;
      bus.full_FIFO    <= (occ_nxt == DEPTH_V);
      bus.empty_FIFO   <= (occ_nxt == '0);
      bus.almost_full  <= (occ_nxt >= AFULL_V);
      bus.almost_empty <= (occ_nxt <= AEMPTY_V);
      bus.error_FIFO   <= rej;
      bus.block_done   <= pop_ok && blk_end;
    end
  end

`ifdef DMA_FIFO_STATUS_EN
  assign fifo_level = occ;

  always_ff @(posedge clk_in_1) begin
    if (clr) begin
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      if (bus.write_1 && !push_ok)
        ovf_sticky <= 1'b1;
      if (bus.read_1 && !pop_ok)
        udf_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dma_byte_fifo.sv
// Self-checking bench for dma_byte_fifo.
// Scoreboard of pushed bytes / expected block_done per pop.
module tb_dma_byte_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_byte_fifo_if bus();

`ifdef DMA_FIFO_STATUS_EN
  logic [3:0] lvl;
  logic       ovf;
  logic       udf;
`endif

  dma_byte_fifo #(
    .DEPTH(8),
    .AFULL_TH(6),
    .AEMPTY_TH(2)
  ) dut (
    .clk_in_1(clk),
    .reset_1(rst_n),
    .bus(bus)
`ifdef DMA_FIFO_STATUS_EN
    ,
    .fifo_level(lvl),
    .ovf_sticky(ovf),
    .udf_sticky(udf)
`endif
  );

  int n_tests = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic       done_q[$];
  int         occ = 0;
  int         bcnt = 0;
  int         blen = 0;
  logic [7:0] e_byte;
  logic       e_done;

  // Output monitor: every valid byte must match the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.valid_out) begin
      n_tests++;
      if (exp_q.size() == 0 || done_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra: got byte %02h, none expected",
                 bus.data_out_FIFO_1);
      end else begin
        e_byte = exp_q.pop_front();
        e_done = done_q.pop_front();
        if (bus.data_out_FIFO_1 !== e_byte ||
            bus.block_done !== e_done) begin
          n_fail++;
          $display("FAIL sb_data: got %02h done=%b, want %02h done=%b",
                   bus.data_out_FIFO_1, bus.block_done, e_byte, e_done);
        end
      end
    end else if (rst_n && bus.block_done !== 1'b0) begin
      n_tests++;
      n_fail++;
      $display("FAIL spurious_done: block_done=%b without valid_out",
               bus.block_done);
    end
  end

  task automatic cycle(input logic w, input logic [7:0] d,
                       input logic r);
    bit push;
    bit pop;
    int len;
    bus.write_1 = w;
    bus.data_in_FIFO_1 = d;
    bus.read_1 = r;
    push = w && (occ < 8 || r);
    pop = r && (occ > 0);
    if (pop) begin
      len = blen;
      if (bcnt == 0) begin
        len = (bus.block_size == 12'd0) ? 4096 : int'(bus.block_size);
        blen = len;
      end
      bcnt++;
      if (bcnt == len) begin
        bcnt = 0;
        done_q.push_back(1'b1);
      end else begin
        done_q.push_back(1'b0);
      end
    end
    if (push) exp_q.push_back(d);
    occ = occ + int'(push) - int'(pop);
    @(posedge clk);
    #1;
    bus.write_1 = 1'b0;
    bus.read_1 = 1'b0;
  endtask

  task automatic clear_model();
    exp_q.delete();
    done_q.delete();
    occ = 0;
    bcnt = 0;
    blen = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.write_1 = 1'b0;
    bus.read_1 = 1'b0;
    bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_model();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [14:0] got;
    do_reset();
    got = {bus.data_out_FIFO_1, bus.valid_out, bus.full_FIFO,
           bus.empty_FIFO, bus.almost_full, bus.almost_empty,
           bus.error_FIFO, bus.block_done};
    n_tests++;
    if (got !== 15'b00000000_0010100) begin
      n_fail++;
      $display("FAIL reset_state: got %015b want %015b",
               got, 15'b00000000_0010100);
    end
  endtask

  task automatic test_basic();
    logic [7:0] pat [4];
    pat[0] = 8'h01; pat[1] = 8'h02; pat[2] = 8'h04; pat[3] = 8'h08;
    bus.block_size = 12'd0;
    for (int i = 0; i < 4; i++) cycle(1'b1, pat[i], 1'b0);
    n_tests++;
    if ({bus.almost_full, bus.almost_empty, bus.empty_FIFO} !== 3'b000) begin
      n_fail++;
      $display("FAIL basic_flags4: got af/ae/e=%b want 000",
               {bus.almost_full, bus.almost_empty, bus.empty_FIFO});
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
    n_tests++;
    if (bus.empty_FIFO !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_empty: got %b want 1", bus.empty_FIFO);
    end
    cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 8'h10 + 8'(i), 1'b0);
      n_tests++;
      if (bus.almost_full !== (occ >= 6) ||
          bus.almost_empty !== (occ <= 2)) begin
        n_fail++;
        $display("FAIL thresh_occ%0d: got af=%b ae=%b want af=%b ae=%b",
                 occ, bus.almost_full, bus.almost_empty,
                 occ >= 6, occ <= 2);
      end
    end
    n_tests++;
    if (bus.full_FIFO !== 1'b1 || bus.error_FIFO !== 1'b0) begin
      n_fail++;
      $display("FAIL full_set: got full=%b err=%b want 1 0",
               bus.full_FIFO, bus.error_FIFO);
    end
    cycle(1'b1, 8'hEE, 1'b0);
    n_tests++;
    if (bus.error_FIFO !== 1'b1 || bus.full_FIFO !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_err: got err=%b full=%b want 1 1",
               bus.error_FIFO, bus.full_FIFO);
    end
`ifdef DMA_FIFO_STATUS_EN
    n_tests++;
    if (ovf !== 1'b1 || lvl !== 4'd8) begin
      n_fail++;
      $display("FAIL ovf_sticky: got ovf=%b lvl=%0d want 1 8", ovf, lvl);
    end
`endif
    cycle(1'b0, 8'h00, 1'b0);
    n_tests++;
    if (bus.error_FIFO !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_pulse: got err=%b want 0", bus.error_FIFO);
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'h20 + 8'(i), 1'b1);
      n_tests++;
      if (bus.full_FIFO !== 1'b1 || bus.error_FIFO !== 1'b0) begin
        n_fail++;
        $display("FAIL full_rw%0d: got full=%b err=%b want 1 0",
                 i, bus.full_FIFO, bus.error_FIFO);
      end
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    n_tests++;
    if (bus.empty_FIFO !== 1'b1 || bus.full_FIFO !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: got empty=%b full=%b want 1 0",
               bus.empty_FIFO, bus.full_FIFO);
    end
  endtask

  task automatic test_empty_rw();
    cycle(1'b1, 8'h5A, 1'b1);
    n_tests++;
    if (bus.error_FIFO !== 1'b1 || bus.valid_out !== 1'b0 ||
        bus.empty_FIFO !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_rw: got err=%b vld=%b empty=%b want 1 0 0",
               bus.error_FIFO, bus.valid_out, bus.empty_FIFO);
    end
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 8'h80, 1'b0);
    for (int i = 1; i < 11; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b1);
    n_tests++;
    if (bus.empty_FIFO !== 1'b0 || bus.almost_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_flags: got empty=%b ae=%b want 0 1",
               bus.empty_FIFO, bus.almost_empty);
    end
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_block();
    do_reset();
    bus.block_size = 12'd3;
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'hB0 + 8'(i), 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    do_reset();
    n_tests++;
    if (bus.block_done !== 1'b0 || bus.empty_FIFO !== 1'b1) begin
      n_fail++;
      $display("FAIL blk_reset: got done=%b empty=%b want 0 1",
               bus.block_done, bus.empty_FIFO);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    bus.block_size = 12'd5;
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_flush();
    bus.block_size = 12'd3;
    cycle(1'b0, 8'h00, 1'b1);
    n_tests++;
    if (bus.error_FIFO !== 1'b1) begin
      n_fail++;
      $display("FAIL udf_err: got err=%b want 1", bus.error_FIFO);
    end
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'hD0 + 8'(i), 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    clear_model();
    n_tests++;
    if (bus.empty_FIFO !== 1'b1 || bus.block_done !== 1'b0 ||
        bus.valid_out !== 1'b0 || bus.data_out_FIFO_1 !== 8'hD1) begin
      n_fail++;
      $display("FAIL flush: got empty=%b done=%b vld=%b dout=%02h want 1 0 0 d1",
               bus.empty_FIFO, bus.block_done, bus.valid_out,
               bus.data_out_FIFO_1);
    end
`ifdef DMA_FIFO_STATUS_EN
    n_tests++;
    if (lvl !== 4'd0 || ovf !== 1'b0 || udf !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_status: got lvl=%0d ovf=%b udf=%b want 0 0 0",
               lvl, ovf, udf);
    end
`endif
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hE0 + 8'(i), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.write_1 = 1'b0;
    bus.read_1 = 1'b0;
    bus.data_in_FIFO_1 = 8'h00;
    bus.block_size = 12'd0;
    test_reset();
    test_basic();
    test_full();
    test_full_rw();
    test_empty_rw();
    test_back_to_back();
    test_block();
    test_flush();
    cycle(1'b0, 8'h00, 1'b0);
    n_tests++;
    if (done_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_missing: got %0d outputs outstanding, want 0",
               done_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
